vend_sequencer: RTL and testbench

Clocked purchase controller for the seven-slot vending machine. It holds per-slot stock and sequences the purchase flow: selection, confirmation, coin acceptance, dispense and change/refund. It also keeps the revenue total and a 30-second inactivity timer. It drives the segment-display and LED logic and takes pulses from the debounced button/switch front end.

---
 rtl/vend_sequencer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: purchase controller for the seven-slot vending machine.
// Holds per-slot stock and sequences selection, confirmation, coin
// acceptance, dispense and change/refund. Keeps the revenue total.
// Optional feature macro: VEND_TIMEOUT_EN enables the payment inactivity
// timer; without it time_left reads 0, tick_1hz is ignored and PAY only
// exits by completion or cancel.
module vend_sequencer #(
   parameter int unsigned TIMEOUT_S  = 30,
   parameter int unsigned INIT_STOCK = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        sel_valid,
   input  logic [2:0]  sel_slot,
   input  logic [2:0]  sel_qty,
   input  logic        confirm,
   input  logic        cancel,
   input  logic        coin_valid,
   input  logic [2:0]  coin_val,
   input  logic        restock_valid,
   input  logic [2:0]  restock_slot,
   input  logic [2:0]  restock_qty,
   output logic [20:0] stock,
   output logic [2:0]  state,
   output logic [5:0]  due,
   output logic [5:0]  paid,
   output logic [5:0]  change,
   output logic [4:0]  time_left,
   output logic        dispense_valid,
   output logic [2:0]  dispense_slot,
   output logic [2:0]  dispense_qty,
   output logic        refund_valid,
   output logic        err_stock,
   output logic [9:0]  revenue
);

   localparam int unsigned SLOT_W = 3;
   localparam int unsigned AMT_W  = 6;
   localparam int unsigned TL_W   = 5;
   localparam int unsigned REV_W  = 10;
   localparam int unsigned NSLOT  = 7;
   localparam logic [TL_W-1:0]   TL_LOAD  = TL_W'(TIMEOUT_S);
   localparam logic [SLOT_W-1:0] STK_INIT = SLOT_W'(INIT_STOCK);
   localparam logic [REV_W-1:0]  REV_MAX  = '1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_PAY      = 3'd2,
      ST_DISPENSE = 3'd3,
      ST_DONE     = 3'd4,
      ST_REFUND   = 3'd5
   } state_t;

   state_t              r_state, w_state_nx;
   logic [SLOT_W-1:0]   r_stock    [1:NSLOT];
   logic [SLOT_W-1:0]   w_stock_nx [1:NSLOT];
   logic [SLOT_W-1:0]   r_slot, w_slot_nx;
   logic [SLOT_W-1:0]   r_qty, w_qty_nx;
   logic [AMT_W-1:0]    r_due, w_due_nx;
   logic [AMT_W-1:0]    r_paid, w_paid_nx;
   logic [AMT_W-1:0]    r_change, w_change_nx;
   logic [REV_W-1:0]    r_revenue, w_revenue_nx;
   logic                r_disp_valid, w_disp_valid_nx;
   logic [SLOT_W-1:0]   r_disp_slot, w_disp_slot_nx;
   logic [SLOT_W-1:0]   r_disp_qty, w_disp_qty_nx;
   logic                r_refund, w_refund_nx;
   logic                r_err, w_err_nx;

   logic                w_coin_ok;
   logic                w_sel_ok;
   logic [AMT_W:0]      w_paid_sum;
   logic [SLOT_W-1:0]   w_cur_stock;
   logic [SLOT_W-1:0]   w_price;
   logic [SLOT_W:0]     w_restock_sum;
   logic [REV_W:0]      w_rev_sum;
   logic [20:0]         w_stock_flat;

`ifdef VEND_TIMEOUT_EN
   logic [TL_W-1:0]     r_time_left, w_tl_nx;
   logic                w_timeout;
`else
   logic                w_unused_tick;
`endif

   // Fixed price table indexed by slot number.
   function automatic logic [SLOT_W-1:0] price_of(input logic [SLOT_W-1:0] slot);
      case (slot)
         3'd1:    price_of = 3'd2;
         3'd2:    price_of = 3'd3;
         3'd3:    price_of = 3'd3;
         3'd4:    price_of = 3'd4;
         3'd5:    price_of = 3'd5;
         3'd6:    price_of = 3'd5;
         3'd7:    price_of = 3'd7;
         default: price_of = 3'd0;
      endcase
   endfunction

   // Input qualification and shared arithmetic.
   always_comb begin
      w_coin_ok   = coin_valid && (coin_val == 3'd1 || coin_val == 3'd2 || coin_val == 3'd5);
      w_sel_ok    = sel_valid && (sel_slot != 3'd0) && (sel_qty != 3'd0);
      w_paid_sum  = (AMT_W+1)'(r_paid) + (AMT_W+1)'(w_coin_ok ? coin_val : 3'd0);
      w_price     = price_of(r_slot);
      w_rev_sum   = (REV_W+1)'(r_revenue) + (REV_W+1)'(r_due);
      w_cur_stock = '0;
      for (int i = 1; i <= int'(NSLOT); i++) begin
         if (r_slot == SLOT_W'(i)) w_cur_stock = r_stock[i];
      end
   end

`ifdef VEND_TIMEOUT_EN
   // Timeout fires on the tick that would take time_left from 1 to 0; a coin wins.
   assign w_timeout = tick_1hz && (r_time_left == TL_W'(1)) && !w_coin_ok;
   assign time_left = r_time_left;
`else
   assign w_unused_tick = tick_1hz ^ (|TL_LOAD);
   assign time_left     = '0;
`endif

   // Next-state and next-output logic for the purchase flow.
   always_comb begin
      w_state_nx      = r_state;
      w_slot_nx       = r_slot;
      w_qty_nx        = r_qty;
      w_due_nx        = r_due;
      w_paid_nx       = r_paid;
      w_change_nx     = r_change;
      w_revenue_nx    = r_revenue;
      w_disp_valid_nx = 1'b0;
      w_disp_slot_nx  = r_disp_slot;
      w_disp_qty_nx   = r_disp_qty;
      w_refund_nx     = 1'b0;
      w_err_nx        = 1'b0;
      w_restock_sum   = '0;
      for (int i = 1; i <= int'(NSLOT); i++) w_stock_nx[i] = r_stock[i];
`ifdef VEND_TIMEOUT_EN
      w_tl_nx = r_time_left;
`endif

      case (r_state)
         ST_IDLE: begin
            if (w_sel_ok) begin
               w_slot_nx  = sel_slot;
               w_qty_nx   = sel_qty;
               w_state_nx = ST_SELECT;
            end
            if (restock_valid && restock_slot != 3'd0) begin
               for (int i = 1; i <= int'(NSLOT); i++) begin
                  if (restock_slot == SLOT_W'(i)) begin
                     w_restock_sum = (SLOT_W+1)'(r_stock[i]) + (SLOT_W+1)'(restock_qty);
                     w_stock_nx[i] = w_restock_sum[SLOT_W] ? 3'd7 : w_restock_sum[SLOT_W-1:0];
                  end
               end
            end
         end

         ST_SELECT: begin
            if (cancel) begin
               w_state_nx = ST_IDLE;
            end else if (confirm) begin
               if (r_qty > w_cur_stock) begin
                  w_err_nx   = 1'b1;
                  w_state_nx = ST_IDLE;
               end else begin
                  w_due_nx    = AMT_W'(w_price) * AMT_W'(r_qty);
                  w_paid_nx   = '0;
                  w_change_nx = '0;
                  w_state_nx  = ST_PAY;
`ifdef VEND_TIMEOUT_EN
                  w_tl_nx = TL_LOAD;
`endif
               end
            end else if (w_sel_ok) begin
               w_slot_nx = sel_slot;
               w_qty_nx  = sel_qty;
            end
         end

         ST_PAY: begin
            if (w_coin_ok) w_paid_nx = AMT_W'(w_paid_sum);
`ifdef VEND_TIMEOUT_EN
            if (w_coin_ok)                             w_tl_nx = TL_LOAD;
            else if (tick_1hz && r_time_left != '0)    w_tl_nx = r_time_left - TL_W'(1);
`endif
            if (cancel) begin
               w_change_nx = AMT_W'(w_paid_sum);
               w_refund_nx = 1'b1;
               w_state_nx  = ST_REFUND;
            end else if (w_coin_ok && w_paid_sum >= (AMT_W+1)'(r_due)) begin
               w_disp_valid_nx = 1'b1;
               w_disp_slot_nx  = r_slot;
               w_disp_qty_nx   = r_qty;
               w_state_nx      = ST_DISPENSE;
            end
`ifdef VEND_TIMEOUT_EN
            else if (w_timeout) begin
               w_change_nx = r_paid;
               w_refund_nx = 1'b1;
               w_state_nx  = ST_REFUND;
            end
`endif
         end

         ST_DISPENSE: begin
            for (int i = 1; i <= int'(NSLOT); i++) begin
               if (r_slot == SLOT_W'(i)) w_stock_nx[i] = r_stock[i] - r_qty;
            end
            w_revenue_nx = w_rev_sum[REV_W] ? REV_MAX : w_rev_sum[REV_W-1:0];
            w_change_nx  = r_paid - r_due;
            w_state_nx   = ST_DONE;
         end

         ST_DONE, ST_REFUND: begin
            if (confirm || cancel) begin
               w_due_nx    = '0;
               w_paid_nx   = '0;
               w_change_nx = '0;
               w_state_nx  = ST_IDLE;
            end
         end

         default: w_state_nx = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_slot       <= '0;
         r_qty        <= '0;
         r_due        <= '0;
         r_paid       <= '0;
         r_change     <= '0;
         r_revenue    <= '0;
         r_disp_valid <= 1'b0;
         r_disp_slot  <= '0;
         r_disp_qty   <= '0;
         r_refund     <= 1'b0;
         r_err        <= 1'b0;
         for (int i = 1; i <= int'(NSLOT); i++) r_stock[i] <= STK_INIT;
      end else begin
         r_state      <= w_state_nx;
         r_slot       <= w_slot_nx;
         r_qty        <= w_qty_nx;
         r_due        <= w_due_nx;
         r_paid       <= w_paid_nx;
         r_change     <= w_change_nx;
         r_revenue    <= w_revenue_nx;
         r_disp_valid <= w_disp_valid_nx;
         r_disp_slot  <= w_disp_slot_nx;
         r_disp_qty   <= w_disp_qty_nx;
         r_refund     <= w_refund_nx;
         r_err        <= w_err_nx;
         for (int i = 1; i <= int'(NSLOT); i++) r_stock[i] <= w_stock_nx[i];
      end
   end

`ifdef VEND_TIMEOUT_EN
   // Inactivity timer register.
   always_ff @(posedge clk) begin
      if (rst) r_time_left <= '0;
      else     r_time_left <= w_tl_nx;
   end
`endif

   // Pack per-slot stock onto the flat display bus.
   always_comb begin
      w_stock_flat = '0;
      for (int i = 1; i <= int'(NSLOT); i++) w_stock_flat[3*i-3 +: 3] = r_stock[i];
   end

   assign stock          = w_stock_flat;
   assign state          = r_state;
   assign due            = r_due;
   assign paid           = r_paid;
   assign change         = r_change;
   assign revenue        = r_revenue;
   assign dispense_valid = r_disp_valid;
   assign dispense_slot  = r_disp_slot;
   assign dispense_qty   = r_disp_qty;
   assign refund_valid   = r_refund;
   assign err_stock      = r_err;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (default parameters).
// Expectations for time_left follow VEND_TIMEOUT_EN if the macro is defined.
module tb_vend_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1hz = 1'b0;
   logic        sel_valid = 1'b0;
   logic [2:0]  sel_slot = '0;
   logic [2:0]  sel_qty = '0;
   logic        confirm = 1'b0;
   logic        cancel = 1'b0;
   logic        coin_valid = 1'b0;
   logic [2:0]  coin_val = '0;
   logic        restock_valid = 1'b0;
   logic [2:0]  restock_slot = '0;
   logic [2:0]  restock_qty = '0;
   logic [20:0] stock;
   logic [2:0]  state;
   logic [5:0]  due, paid, change;
   logic [4:0]  time_left;
   logic        dispense_valid, refund_valid, err_stock;
   logic [2:0]  dispense_slot, dispense_qty;
   logic [9:0]  revenue;

   int n_asserts = 0;
   int n_fail    = 0;

   localparam logic [20:0] STOCK_INIT = {7{3'd5}};
`ifdef VEND_TIMEOUT_EN
   localparam int TL_FULL = 30;
`else
   localparam int TL_FULL = 0;
`endif

   vend_sequencer dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .sel_valid(sel_valid), .sel_slot(sel_slot), .sel_qty(sel_qty),
      .confirm(confirm), .cancel(cancel),
      .coin_valid(coin_valid), .coin_val(coin_val),
      .restock_valid(restock_valid), .restock_slot(restock_slot), .restock_qty(restock_qty),
      .stock(stock), .state(state), .due(due), .paid(paid), .change(change),
      .time_left(time_left), .dispense_valid(dispense_valid),
      .dispense_slot(dispense_slot), .dispense_qty(dispense_qty),
      .refund_valid(refund_valid), .err_stock(err_stock), .revenue(revenue)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] stk(input int n);
      logic [20:0] s;
      s = stock;
      return s[3*n-1 -: 3];
   endfunction

   // One clock: inputs already set are sampled, outputs checked 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_sel(input logic [2:0] s, input logic [2:0] q);
      sel_valid = 1'b1; sel_slot = s; sel_qty = q;
      cyc();
      sel_valid = 1'b0;
   endtask

   task automatic do_confirm();
      confirm = 1'b1; cyc(); confirm = 1'b0;
   endtask

   task automatic do_coin(input logic [2:0] v);
      coin_valid = 1'b1; coin_val = v; cyc(); coin_valid = 1'b0;
   endtask

   task automatic do_ticks(input int n);
      tick_1hz = 1'b1;
      for (int k = 0; k < n; k++) cyc();
      tick_1hz = 1'b0;
   endtask

   task automatic do_restock(input logic [2:0] s, input logic [2:0] q);
      restock_valid = 1'b1; restock_slot = s; restock_qty = q;
      cyc();
      restock_valid = 1'b0;
   endtask

   initial begin
      // Reset values
      rst = 1'b1; cyc(); cyc(); rst = 1'b0;
      check("rst_state", 32'(state), 0);
      check("rst_stock", 32'(stock), 32'(STOCK_INIT));
      check("rst_due", 32'(due), 0);
      check("rst_paid", 32'(paid), 0);
      check("rst_change", 32'(change), 0);
      check("rst_revenue", 32'(revenue), 0);
      check("rst_time_left", 32'(time_left), 0);
      check("rst_disp", 32'({dispense_valid, dispense_slot, dispense_qty}), 0);
      check("rst_pulses", 32'({refund_valid, err_stock}), 0);

      // Invalid selection ignored
      do_sel(3'd0, 3'd1);
      check("sel_invalid_state", 32'(state), 0);

      // Slot 4 qty 2, coins 5,5
      do_sel(3'd4, 3'd2);
      check("t1_select", 32'(state), 1);
      do_confirm();
      check("t1_pay", 32'(state), 2);
      check("t1_due", 32'(due), 8);
      check("t1_tl", 32'(time_left), 32'(TL_FULL));
      do_coin(3'd5);
      check("t1_paid5", 32'(paid), 5);
      check("t1_still_pay", 32'(state), 2);
      do_coin(3'd5);
      check("t1_disp_state", 32'(state), 3);
      check("t1_disp_valid", 32'(dispense_valid), 1);
      check("t1_disp_slot", 32'(dispense_slot), 4);
      check("t1_disp_qty", 32'(dispense_qty), 2);
      check("t1_paid10", 32'(paid), 10);
      cyc();
      check("t1_done", 32'(state), 4);
      check("t1_disp_off", 32'(dispense_valid), 0);
      check("t1_change", 32'(change), 2);
      check("t1_stock4", 32'(stk(4)), 3);
      check("t1_stock3", 32'(stk(3)), 5);
      check("t1_revenue", 32'(revenue), 8);
      do_confirm();
      check("t1_idle", 32'(state), 0);
      check("t1_clr", 32'({due, paid, change}), 0);

      // Slot 7 qty 6: insufficient stock
      do_sel(3'd7, 3'd6);
      do_confirm();
      check("t2_err", 32'(err_stock), 1);
      check("t2_state", 32'(state), 0);
      check("t2_stock7", 32'(stk(7)), 5);
      cyc();
      check("t2_err_off", 32'(err_stock), 0);

      // Slot 1 qty 3, coin 2, then timeout (or cancel when timer absent)
      do_sel(3'd1, 3'd3);
      do_confirm();
      check("t3_due", 32'(due), 6);
      do_coin(3'd2);
      check("t3_paid", 32'(paid), 2);
      do_ticks(29);
      check("t3_tl1", 32'(time_left), (TL_FULL == 0) ? 0 : 1);
      check("t3_pay", 32'(state), 2);
      do_ticks(1);
`ifdef VEND_TIMEOUT_EN
      check("t3_refund_state", 32'(state), 5);
      check("t3_refund_valid", 32'(refund_valid), 1);
      check("t3_tl0", 32'(time_left), 0);
`else
      check("t3_no_timeout", 32'(state), 2);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      check("t3_refund_state", 32'(state), 5);
      check("t3_refund_valid", 32'(refund_valid), 1);
`endif
      check("t3_change", 32'(change), 2);
      cyc();
      check("t3_refund_off", 32'(refund_valid), 0);
      check("t3_change_hold", 32'(change), 2);
      do_confirm();
      check("t3_idle", 32'(state), 0);

      // Coin and final tick together: coin wins, timer reloads
      do_sel(3'd2, 3'd1);
      do_confirm();
      do_ticks(29);
      tick_1hz = 1'b1; coin_valid = 1'b1; coin_val = 3'd1;
      cyc();
      tick_1hz = 1'b0; coin_valid = 1'b0;
      check("t3b_state", 32'(state), 2);
      check("t3b_tl", 32'(time_left), 32'(TL_FULL));
      check("t3b_paid", 32'(paid), 1);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      check("t3b_change", 32'(change), 1);
      do_confirm();

      // Slot 4 qty 1 (due 4), coin 2, then cancel + coin 2 together
      do_sel(3'd4, 3'd1);
      do_confirm();
      check("t4_due", 32'(due), 4);
      do_coin(3'd2);
      cancel = 1'b1; coin_valid = 1'b1; coin_val = 3'd2;
      cyc();
      cancel = 1'b0; coin_valid = 1'b0;
      check("t4_state", 32'(state), 5);
      check("t4_change", 32'(change), 4);
      check("t4_refund", 32'(refund_valid), 1);
      check("t4_no_disp", 32'(dispense_valid), 0);
      check("t4_revenue", 32'(revenue), 8);
      do_confirm();

      // Restock saturation in IDLE, then ignored in PAY
      do_restock(3'd2, 3'd5);
      check("t5_stock2", 32'(stk(2)), 7);
      do_sel(3'd3, 3'd2);
      do_confirm();
      check("t5_due", 32'(due), 6);
      do_restock(3'd3, 3'd1);
      check("t5_restock_pay", 32'(stk(3)), 5);
      do_coin(3'd3);
      check("t5_bad_coin", 32'(paid), 0);
      do_coin(3'd2);
      do_coin(3'd1);
      check("t5_paid3", 32'(paid), 3);
      check("t5_pay", 32'(state), 2);

      // Reset mid-payment
      rst = 1'b1; cyc(); rst = 1'b0;
      check("t6_state", 32'(state), 0);
      check("t6_paid", 32'(paid), 0);
      check("t6_due", 32'(due), 0);
      check("t6_refund", 32'(refund_valid), 0);
      check("t6_stock", 32'(stock), 32'(STOCK_INIT));
      check("t6_revenue", 32'(revenue), 0);
      check("t6_tl", 32'(time_left), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
